// File: rtl/spcpu_fetch_unit_pkg.sv
// Shared types for the instruction fetch unit: FSM states, prefetch FIFO entry
// and the instruction group that marks a 32-bit encoding.
package pkg_fetch;

    localparam int FETCH_ADDR_MAX = 32;
    localparam logic [2:0] GRP_32BIT = 3'd5;

    typedef enum logic {
        FETCH = 1'b0,
        DRAIN = 1'b1
    } fetch_state_t;

    // Addresses are stored zero-extended so one entry type serves every ADDR_W up to 32.
    typedef struct packed {
        logic [FETCH_ADDR_MAX-1:0] addr;
        logic [15:0]               data;
    } fetch_entry_t;

endpackage

// File: rtl/instr_group_decoder.sv
// Major-group decode of an instruction halfword; group 5 (instr_grp_5) is the
// prefix of a two-halfword instruction.
module instr_group_decoder (
    input  logic [15:0] halfword,
    output logic [2:0]  instr_group
);

    assign instr_group = halfword[15:13];

endmodule

// File: rtl/spcpu_fetch_unit_fifo.sv
// Prefetch circular buffer: show-ahead head and head+1 data, pops of one or two
// entries, simultaneous push/pop, and a flush that empties it in one cycle.
module spcpu_fetch_fifo
    import pkg_fetch::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               push,
    input  fetch_entry_t       push_entry,
    input  logic               pop_one,
    input  logic               pop_two,
    output fetch_entry_t       head_entry,
    output logic [15:0]        next_data,
    output logic [CNT_W-1:0]   count
);

    fetch_entry_t entries [DEPTH];
    logic [PTR_W-1:0] head_ptr;
    logic [PTR_W-1:0] tail_ptr;
    logic [PTR_W-1:0] head_ptr_p1;
    logic [1:0]       pop_n;

    assign pop_n       = pop_two ? 2'd2 : (pop_one ? 2'd1 : 2'd0);
    assign head_ptr_p1 = head_ptr + PTR_W'(1);
    assign head_entry  = entries[head_ptr];
    assign next_data   = entries[head_ptr_p1].data;

    always_ff @(posedge clk) begin
        if (push) begin
            entries[tail_ptr] <= push_entry;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else begin
            if (push) begin
                tail_ptr <= tail_ptr + PTR_W'(1);
            end
            head_ptr <= head_ptr + PTR_W'(pop_n);
            count    <= count + CNT_W'(push) - CNT_W'(pop_n);
        end
    end

endmodule

// File: rtl/spcpu_fetch_unit.sv
// Instruction fetch unit: halfword prefetch into a small FIFO, 16/32-bit
// instruction assembly at the head, and redirect handling with a DRAIN state.
module spcpu_fetch_unit
    import pkg_fetch::*;
#(
    parameter int              ADDR_W     = 16,
    parameter int              FIFO_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [15:0]       mem_rdata,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [15:0]       instr_hi,
    output logic [15:0]       instr_lo,
    output logic              instr_is_32,
    output logic [ADDR_W-1:0] instr_pc
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    fetch_state_t      state;
    logic [ADDR_W-1:0] fetch_addr;
    logic [ADDR_W-1:0] pending_pc;
    logic [ADDR_W-1:0] redirect_target;
    logic [CNT_W-1:0]  fifo_count;
    fetch_entry_t      head_entry;
    fetch_entry_t      push_entry;
    logic [15:0]       next_data;
    logic [2:0]        head_group;
    logic              head_is_32;
    logic              have_instr;
    logic              ack_taken;
    logic              push;
    logic              pop_one;
    logic              pop_two;

    assign redirect_target = {redirect_pc[ADDR_W-1:1], 1'b0};
    assign mem_req   = !reset && ((state == DRAIN) || (fifo_count < CNT_W'(FIFO_DEPTH)));
    assign mem_addr  = fetch_addr;
    assign ack_taken = mem_req && mem_ack;

    // Data acked alongside a redirect, or while draining, belongs to the old stream.
    assign push       = (state == FETCH) && ack_taken && !redirect;
    assign push_entry = '{addr: FETCH_ADDR_MAX'(fetch_addr), data: mem_rdata};

    assign head_is_32 = (head_group == GRP_32BIT);
    assign have_instr = head_is_32 ? (fifo_count >= CNT_W'(2)) : (fifo_count != '0);
    assign pop_one    = have_instr && instr_ready && !redirect && !head_is_32;
    assign pop_two    = have_instr && instr_ready && !redirect && head_is_32;

    assign instr_valid = have_instr;
    assign instr_is_32 = have_instr && head_is_32;
    assign instr_hi    = have_instr ? head_entry.data : '0;
    assign instr_lo    = (have_instr && head_is_32) ? next_data : '0;
    assign instr_pc    = have_instr ? ADDR_W'(head_entry.addr) : '0;

    // An outstanding unacked request must complete at its original address, so a
    // redirect then parks the target in pending_pc until the ack arrives.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= FETCH;
            fetch_addr <= RESET_PC;
            pending_pc <= '0;
        end else begin
            case (state)
                FETCH: begin
                    if (redirect) begin
                        if (mem_req && !mem_ack) begin
                            state      <= DRAIN;
                            pending_pc <= redirect_target;
                        end else begin
                            fetch_addr <= redirect_target;
                        end
                    end else if (ack_taken) begin
                        fetch_addr <= fetch_addr + ADDR_W'(2);
                    end
                end
                DRAIN: begin
                    if (mem_ack) begin
                        state      <= FETCH;
                        fetch_addr <= redirect ? redirect_target : pending_pc;
                    end else if (redirect) begin
                        pending_pc <= redirect_target;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

    spcpu_fetch_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .flush      (redirect),
        .push       (push),
        .push_entry (push_entry),
        .pop_one    (pop_one),
        .pop_two    (pop_two),
        .head_entry (head_entry),
        .next_data  (next_data),
        .count      (fifo_count)
    );

    instr_group_decoder u_group_dec (
        .halfword    (head_entry.data),
        .instr_group (head_group)
    );

endmodule

// File: tb/tb_spcpu_fetch_unit.sv
// Directed bench for spcpu_fetch_unit: a default instance for streaming,
// backpressure, redirect and reset cases, plus one started at FFFE for wrap.
module tb_spcpu_fetch_unit;

    logic        clk;
    logic        reset;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr_hi;
    logic [15:0] instr_lo;
    logic        instr_is_32;
    logic [15:0] instr_pc;

    logic        w_mem_req;
    logic [15:0] w_mem_addr;
    logic [15:0] w_mem_rdata;
    logic        w_instr_valid;
    logic [15:0] w_instr_hi;
    logic [15:0] w_instr_lo;
    logic        w_instr_is_32;
    logic [15:0] w_instr_pc;

    int n_compared;
    int n_mismatched;
    int acks;

    // Memory image: 0010 holds a group-5 prefix, every other address a 16-bit instruction.
    function automatic logic [15:0] rom(input logic [15:0] a);
        if (a == 16'h0010) return 16'hA123;
        return {4'h1, a[11:0]};
    endfunction

    assign mem_rdata   = rom(mem_addr);
    assign w_mem_rdata = rom(w_mem_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    spcpu_fetch_unit dut (
        .clk         (clk),
        .reset       (reset),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr_hi    (instr_hi),
        .instr_lo    (instr_lo),
        .instr_is_32 (instr_is_32),
        .instr_pc    (instr_pc)
    );

    spcpu_fetch_unit #(
        .ADDR_W     (16),
        .FIFO_DEPTH (4),
        .RESET_PC   (16'hFFFE)
    ) dut_wrap (
        .clk         (clk),
        .reset       (reset),
        .mem_req     (w_mem_req),
        .mem_addr    (w_mem_addr),
        .mem_ack     (1'b1),
        .mem_rdata   (w_mem_rdata),
        .redirect    (1'b0),
        .redirect_pc (16'h0000),
        .instr_valid (w_instr_valid),
        .instr_ready (1'b1),
        .instr_hi    (w_instr_hi),
        .instr_lo    (w_instr_lo),
        .instr_is_32 (w_instr_is_32),
        .instr_pc    (w_instr_pc)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic ack, input logic ready, input logic redir, input logic [15:0] rpc);
        mem_ack     = ack;
        instr_ready = ready;
        redirect    = redir;
        redirect_pc = rpc;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        n_compared   = 0;
        n_mismatched = 0;

        // Reset state and streaming of 16-bit instructions.
        reset = 1'b1;
        applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000);
        tick();
        tick();
        checkOutput("rst_mem_req", 32'(mem_req), 32'd0);
        checkOutput("rst_valid", 32'(instr_valid), 32'd0);
        checkOutput("rst_mem_addr", 32'(mem_addr), 32'h0000);
        checkOutput("rst_instr_hi", 32'(instr_hi), 32'h0000);
        checkOutput("rst_instr_pc", 32'(instr_pc), 32'h0000);
        checkOutput("wrap_rst_addr", 32'(w_mem_addr), 32'hFFFE);
        reset = 1'b0;
        #1;
        checkOutput("rel_mem_req", 32'(mem_req), 32'd1);
        checkOutput("rel_mem_addr", 32'(mem_addr), 32'h0000);
        checkOutput("wrap_rel_req", 32'(w_mem_req), 32'd1);
        for (int k = 1; k <= 8; k++) begin
            tick();
            checkOutput("stream_addr", 32'(mem_addr), 32'(2 * k));
            checkOutput("stream_valid", 32'(instr_valid), 32'd1);
            checkOutput("stream_pc", 32'(instr_pc), 32'(2 * (k - 1)));
            checkOutput("stream_hi", 32'(instr_hi), 32'h1000 + 32'(2 * (k - 1)));
            if (k == 1) begin
                checkOutput("wrap_addr", 32'(w_mem_addr), 32'h0000);
                checkOutput("wrap_pc", 32'(w_instr_pc), 32'hFFFE);
                checkOutput("wrap_hi", 32'(w_instr_hi), 32'h1FFE);
            end
        end

        // 32-bit instruction at 0010/0012.
        tick();
        checkOutput("g5_wait_valid", 32'(instr_valid), 32'd0);
        tick();
        checkOutput("g5_valid", 32'(instr_valid), 32'd1);
        checkOutput("g5_is32", 32'(instr_is_32), 32'd1);
        checkOutput("g5_pc", 32'(instr_pc), 32'h0010);
        checkOutput("g5_hi", 32'(instr_hi), 32'hA123);
        checkOutput("g5_lo", 32'(instr_lo), 32'h1012);
        tick();
        checkOutput("g5_popped_pc", 32'(instr_pc), 32'h0014);
        checkOutput("g5_next_is32", 32'(instr_is_32), 32'd0);
        checkOutput("g5_next_lo", 32'(instr_lo), 32'h0000);

        // Backpressure: FIFO fills after exactly four acks.
        reset = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
        tick();
        reset = 1'b0;
        #1;
        acks = 0;
        for (int i = 0; i < 8; i++) begin
            if (mem_req && mem_ack) acks++;
            tick();
        end
        checkOutput("full_acks", 32'(acks), 32'd4);
        checkOutput("full_mem_req", 32'(mem_req), 32'd0);
        checkOutput("full_pc", 32'(instr_pc), 32'h0000);
        applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
        checkOutput("refill_mem_req", 32'(mem_req), 32'd1);
        checkOutput("refill_addr", 32'(mem_addr), 32'h0008);
        checkOutput("refill_pc", 32'(instr_pc), 32'h0002);

        // Redirect while the request to 0006 is unacked.
        reset = 1'b1;
        applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000);
        tick();
        reset = 1'b0;
        #1;
        tick();
        tick();
        tick();
        checkOutput("drain_pre_addr", 32'(mem_addr), 32'h0006);
        applyStimulus(1'b0, 1'b1, 1'b1, 16'h8001);
        tick();
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);
        checkOutput("drain_hold_addr1", 32'(mem_addr), 32'h0006);
        checkOutput("drain_req", 32'(mem_req), 32'd1);
        checkOutput("drain_valid", 32'(instr_valid), 32'd0);
        tick();
        checkOutput("drain_hold_addr2", 32'(mem_addr), 32'h0006);
        applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000);
        tick();
        checkOutput("drain_new_addr", 32'(mem_addr), 32'h8000);
        checkOutput("drain_dropped", 32'(instr_valid), 32'd0);
        tick();
        checkOutput("drain_new_pc", 32'(instr_pc), 32'h8000);
        checkOutput("drain_new_hi", 32'(instr_hi), 32'h1000);

        // Redirect coinciding with an ack: no DRAIN, data discarded.
        applyStimulus(1'b1, 1'b1, 1'b1, 16'h0041);
        tick();
        applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000);
        checkOutput("redir_ack_addr", 32'(mem_addr), 32'h0040);
        checkOutput("redir_ack_valid", 32'(instr_valid), 32'd0);
        tick();
        checkOutput("redir_ack_pc", 32'(instr_pc), 32'h0040);
        checkOutput("redir_ack_hi", 32'(instr_hi), 32'h1040);

        // Second redirect during DRAIN replaces the target.
        applyStimulus(1'b0, 1'b1, 1'b1, 16'h0100);
        tick();
        applyStimulus(1'b0, 1'b1, 1'b1, 16'h0200);
        checkOutput("redir2_hold1", 32'(mem_addr), 32'h0042);
        tick();
        applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000);
        checkOutput("redir2_hold2", 32'(mem_addr), 32'h0042);
        tick();
        checkOutput("redir2_addr", 32'(mem_addr), 32'h0200);
        checkOutput("redir2_valid", 32'(instr_valid), 32'd0);

        // Reset mid-stream with three entries buffered.
        reset = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
        tick();
        reset = 1'b0;
        #1;
        tick();
        tick();
        tick();
        checkOutput("mid_pre_valid", 32'(instr_valid), 32'd1);
        reset = 1'b1;
        #1;
        checkOutput("mid_req_in_reset", 32'(mem_req), 32'd0);
        tick();
        checkOutput("mid_rst_req", 32'(mem_req), 32'd0);
        checkOutput("mid_rst_valid", 32'(instr_valid), 32'd0);
        checkOutput("mid_rst_addr", 32'(mem_addr), 32'h0000);
        reset = 1'b0;
        #1;
        checkOutput("mid_rel_req", 32'(mem_req), 32'd1);
        checkOutput("mid_rel_addr", 32'(mem_addr), 32'h0000);
        checkOutput("mid_rel_valid", 32'(instr_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/spcpu_fetch_unit.md
SPCPU_FETCH_UNIT -- requirements
Module: spcpu_fetch_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, address width in bits (>=8).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, halfword prefetch entries (power of 2, >=2).
REQ-003 SHALL have parameter RESET_PC, default 0, first fetch address (bit 0 = 0).
REQ-004 SHALL have port clk  in  1  clock; all state on posedge.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have port mem_req  out  1  fetch request pending.
REQ-007 SHALL have port mem_addr  out  ADDR_W  halfword fetch address.
REQ-008 SHALL have port mem_ack  in  1  mem_rdata valid; completes request this cycle.
REQ-009 SHALL have port mem_rdata  in  16  fetched halfword.
REQ-010 SHALL have port redirect  in  1  branch/call/PC-write flush.
REQ-011 SHALL have port redirect_pc  in  ADDR_W  new fetch address.
REQ-012 SHALL have port instr_valid  out  1  complete instruction presented.
REQ-013 SHALL have port instr_ready  in  1  consumer accepts instruction.
REQ-014 SHALL have port instr_hi  out  16  first halfword (whole 16-bit instruction).
REQ-015 SHALL have port instr_lo  out  16  second halfword; 0 when instr_is_32=0.
REQ-016 SHALL have port instr_is_32  out  1  presented instruction is 32-bit.
REQ-017 SHALL have port instr_pc  out  ADDR_W  address of instr_hi.

Function
REQ-018 SHALL keep at most one memory request outstanding; mem_addr stable while mem_req=1 and mem_ack=0.
REQ-019 SHALL assert mem_req when FIFO count < FIFO_DEPTH in state FETCH, or always in state DRAIN; mem_req=0 while reset=1.
REQ-020 SHALL, on mem_req&&mem_ack in FETCH, push {mem_addr, mem_rdata} and advance mem_addr by 2 modulo 2^ADDR_W (wrap all-ones-minus-1 to 0).
REQ-021 SHALL classify head halfword as 32-bit iff it decodes as instr_grp_5 via instr_group_decoder.
REQ-022 SHALL assert instr_valid when FIFO holds head 16-bit instr (count>=1) or head 32-bit instr (count>=2); outputs are show-ahead from FIFO head.
REQ-023 SHALL pop 1 (16-bit) or 2 (32-bit) entries on instr_valid&&instr_ready; push and pop in same cycle both take effect.
REQ-024 SHALL give latency: ack in cycle N -> instr_valid in cycle N+1 for a 16-bit instr into empty FIFO.
REQ-025 SHALL sustain one halfword per cycle when mem_ack is held high and consumer always ready.
REQ-026 SHALL, on redirect, flush FIFO next cycle, set next fetch address to {redirect_pc[ADDR_W-1:1],1'b0}; instr_valid=0 the cycle after redirect.
REQ-027 SHALL, on redirect while mem_req=1 and mem_ack=0, enter DRAIN: hold old mem_addr until mem_ack, discard that data, then return to FETCH at the redirect address.
REQ-028 SHALL discard data acked in the same cycle as redirect and issue the redirect address next cycle (no DRAIN).
REQ-029 SHALL give redirect priority over a same-cycle pop; the handshake is ignored.
REQ-030 SHALL, on a second redirect during DRAIN, replace the pending target; DRAIN continues.
REQ-031 SHALL implement states FETCH and DRAIN only; reset enters FETCH.

Reset
REQ-032 SHALL on reset set mem_req=0, mem_addr=RESET_PC, FIFO empty, instr_valid=0, instr_hi/lo/is_32/pc=0, state FETCH.
REQ-033 SHALL abandon any outstanding request on reset; an ack during reset is ignored.
REQ-034 SHALL assert mem_req at RESET_PC in the first cycle after reset deasserts.

Structure
REQ-035 SHALL place fetch state enum and FIFO entry struct typedef in shared package pkg_fetch; widths derive from parameters.
REQ-036 SHALL instantiate one sub-module spcpu_fetch_fifo (parametrised circular buffer, head/tail pointers, count) plus existing instr_group_decoder on the head halfword.

Verification
REQ-037 SHALL test reset release, mem_ack always 1, 16-bit instrs at 0000,0002 -> mem_addr 0000,0002,0004 on consecutive cycles; instr_pc 0000 one cycle after first ack.
REQ-038 SHALL test group-5 halfword at 0010 plus 0012 -> single instr_valid with instr_is_32=1, instr_pc 0010, both entries popped.
REQ-039 SHALL test instr_ready=0 with FIFO_DEPTH=4 -> exactly 4 acks then mem_req=0; one pop -> mem_req=1 next cycle.
REQ-040 SHALL test redirect to 8001 while request to 0006 unacked -> mem_addr holds 0006 until ack, data dropped, then mem_addr=8000.
REQ-041 SHALL test ADDR_W=16, RESET_PC=FFFE -> fetches FFFE then 0000.
REQ-042 SHALL test reset asserted mid-stream with FIFO at 3 -> next cycle mem_req=0, instr_valid=0, mem_addr=RESET_PC.
